// File: rtl/csa_row_sequencer.sv
// Serial-in / serial-out wrapper around an eight-operand carry-save adder.
// Define CSA_ROW_SEQ_OVERLAP_EN to collect the next row while a result waits.
module csa_eight #(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [SIZE-1:0] c,
  input  logic [SIZE-1:0] d,
  input  logic [SIZE-1:0] e,
  input  logic [SIZE-1:0] f,
  input  logic [SIZE-1:0] g,
  input  logic [SIZE-1:0] h,
  input  logic [SIZE-1:0] k,
  input  logic            approx_en,
  output logic [SIZE+3:0] sum
);
  localparam int W = SIZE + 4;

  function automatic logic [2*W-1:0] fa(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [W-1:0] z
  );
    logic [W-1:0] cy;
    cy = (x & y) | (x & z) | (y & z);
    return {x ^ y ^ z, cy[W-2:0], 1'b0};
  endfunction

  logic [W-1:0] x [9];
  logic [W-1:0] s1 [6];
  logic [W-1:0] s2 [4];
  logic [W-1:0] s3 [3];
  logic [W-1:0] s4 [2];
  logic [W-1:0] exact;

  always_comb begin
    x[0] = W'($signed(a));
    x[1] = W'($signed(b));
    x[2] = W'($signed(c));
    x[3] = W'($signed(d));
    x[4] = W'($signed(e));
    x[5] = W'($signed(f));
    x[6] = W'($signed(g));
    x[7] = W'($signed(h));
    x[8] = W'($signed(k));
    // 9 -> 6 -> 4 -> 3 -> 2 reduction, modulo 2^W
    {s1[0], s1[1]} = fa(x[0], x[1], x[2]);
    {s1[2], s1[3]} = fa(x[3], x[4], x[5]);
    {s1[4], s1[5]} = fa(x[6], x[7], x[8]);
    {s2[0], s2[1]} = fa(s1[0], s1[1], s1[2]);
    {s2[2], s2[3]} = fa(s1[3], s1[4], s1[5]);
    {s3[0], s3[1]} = fa(s2[0], s2[1], s2[2]);
    s3[2] = s2[3];
    {s4[0], s4[1]} = fa(s3[0], s3[1], s3[2]);
    exact = s4[0] + s4[1];
    sum = exact;
    for (int i = 0; i < W; i++) begin
      if (approx_en && i < APPROX_BITS) begin
        sum[i] = s4[0][i] | s4[1][i];
      end
    end
  end
endmodule

module csa_row_sequencer #(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic [SIZE-1:0] constant,
  input  logic            approx_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE+4:0] out_sum
);
  typedef enum logic [1:0] {
    COLLECT,
    SUM,
    OUT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [SIZE-1:0] ops_q [8];
  logic [SIZE-1:0] ops_d [8];
  logic [SIZE-1:0] cst_q, cst_d;
  logic            apx_q, apx_d;
  logic [SIZE+4:0] sum_q, sum_d;
  logic            vld_q, vld_d;
  logic            en_q, en_d;
  logic [SIZE+3:0] csa_sum;
  logic            acc;
  logic            last;

  csa_eight #(
    .SIZE       (SIZE),
    .APPROX_BITS(APPROX_BITS)
  ) u_csa (
    .a        (ops_q[0]),
    .b        (ops_q[1]),
    .c        (ops_q[2]),
    .d        (ops_q[3]),
    .e        (ops_q[4]),
    .f        (ops_q[5]),
    .g        (ops_q[6]),
    .h        (ops_q[7]),
    .k        (cst_q),
    .approx_en(apx_q),
    .sum      (csa_sum)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    cst_d   = cst_q;
    apx_d   = apx_q;
    sum_d   = sum_q;
    vld_d   = vld_q;
    en_d    = 1'b1;
`ifdef CSA_ROW_SEQ_OVERLAP_EN
    // only the row-closing sample waits for an unaccepted result
    in_ready = en_q &&
      !(idx_q == 3'd7 && vld_q && !out_ready);
`else
    in_ready = en_q && (state_q == COLLECT);
`endif
    acc  = in_valid && in_ready;
    last = acc && (idx_q == 3'd7);
    if (acc) begin
      ops_d[idx_q] = in_data;
      idx_d        = idx_q + 3'd1;
      if (idx_q == 3'd0) begin
        cst_d = constant;
        apx_d = approx_en;
      end
    end
    unique case (state_q)
      COLLECT: begin
        if (last) state_d = SUM;
      end
      SUM: begin
        sum_d   = {csa_sum[SIZE+3], csa_sum};
        vld_d   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = last ? SUM : COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= 3'd0;
      for (int i = 0; i < 8; i++) ops_q[i] <= '0;
      cst_q   <= '0;
      apx_q   <= 1'b0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
      cst_q   <= cst_d;
      apx_q   <= apx_d;
      sum_q   <= sum_d;
      vld_q   <= vld_d;
      en_q    <= en_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = sum_q;
endmodule

// File: tb/tb_csa_row_sequencer.sv
// Bench for csa_row_sequencer: row table plus scoreboard.
// Overlap checks build when CSA_ROW_SEQ_OVERLAP_EN is defined.
module tb_csa_row_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  constant;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q [$];
  int rise_q [$];
  logic pv = 1'b0;

  csa_row_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .constant (constant),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // scoreboard: compare each result on the cycle its handshake completes
  always @(negedge clk) begin
    if (out_valid && !pv) rise_q.push_back(cyc);
    pv = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", $signed(out_sum), -99999);
      end else begin
        chk("out_sum", $signed(out_sum), exp_q.pop_front());
      end
    end
  end

  task automatic send_sample(input logic [7:0] d, input logic [7:0] c,
                             input logic a, output int st);
    logic r;
    bit   done;
    st = 0;
    done = 0;
    in_valid = 1'b1;
    in_data = d;
    constant = c;
    approx_en = a;
    while (!done && st < 64) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) done = 1;
      else st++;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_row(input int base, input int step, input int c0,
                          input int cm, input logic a, input int exp,
                          output int stalls);
    int st;
    logic [7:0] d;
    logic [7:0] c;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      d = 8'(base + i * step);
      c = (i < 4) ? 8'(c0) : 8'(cm);
      if (i == 7) exp_q.push_back(exp);
      send_sample(d, c, a, st);
      stalls += st;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  typedef struct {
    int   base;
    int   step;
    int   c0;
    int   cm;
    logic apx;
    int   exp;
  } row_t;

  row_t rows [7];
  int   st;

  initial begin
    rows[0] = '{1, 1, 0, 0, 1'b0, 36};
    rows[1] = '{-128, 0, -128, -128, 1'b0, -1152};
    rows[2] = '{127, 0, 127, 127, 1'b0, 1143};
    rows[3] = '{1, 0, 10, 99, 1'b0, 18};
    rows[4] = '{9, 1, 0, 0, 1'b0, 100};
    rows[5] = '{-5, 3, 7, 7, 1'b1, 51};
    rows[6] = '{-100, 25, -3, 50, 1'b0, -103};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    constant = '0;
    approx_en = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", in_ready, 1);

    // latency: result visible one edge after SUM, for one cycle
    send_row(1, 1, 0, 0, 1'b0, 36, st);
    chk("lat_valid_n", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid_n1", out_valid, 1);
    chk("lat_sum", $signed(out_sum), 36);
    @(posedge clk);
    #1;
    chk("lat_valid_n2", out_valid, 0);

    for (int i = 0; i < 7; i++) begin
      send_row(rows[i].base, rows[i].step, rows[i].c0,
               rows[i].cm, rows[i].apx, rows[i].exp, st);
    end
    wait_drain();

    // output back-pressure
    out_ready = 1'b0;
    send_row(1, 1, 0, 0, 1'b0, 36, st);
    for (int n = 0; n < 10 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", $signed(out_sum), 36);
`ifndef CSA_ROW_SEQ_OVERLAP_EN
      chk("hold_in_ready", in_ready, 0);
`endif
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid_clear", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    wait_drain();

    // asynchronous reset discards a partial row
    for (int i = 0; i < 4; i++) send_sample(8'd50, 8'd0, 1'b0, st);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_row(2, 0, 0, 0, 1'b0, 16, st);
    wait_drain();

`ifdef CSA_ROW_SEQ_OVERLAP_EN
    rise_q.delete();
    send_row(1, 1, 0, 0, 1'b0, 36, st);
    send_row(9, 1, 0, 0, 1'b0, 100, st);
    chk("ovl_row2_stalls", st, 0);
    wait_drain();
    chk("ovl_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      chk("ovl_period", rise_q[1] - rise_q[0], 8);
    end

    out_ready = 1'b0;
    send_row(1, 1, 0, 0, 1'b0, 36, st);
    begin
      int tot = 0;
      for (int i = 0; i < 7; i++) begin
        send_sample(8'(9 + i), 8'd0, 1'b0, st);
        tot += st;
      end
      chk("ovl_first7_stalls", tot, 0);
    end
    in_valid = 1'b1;
    in_data = 8'd16;
    exp_q.push_back(100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ovl_stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ovl_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
